// File: rtl/booth_row_pkg.sv
// Shared types and sizing helpers for the booth systolic row and its east-edge
// drain sequencer; the saturation limits are the same ones the PE uses.
package booth_row_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FIRE,
      S_WAIT,
      S_CAPTURE
   } drain_state_t;

   // Width of the partial sum leaving the last PE of a row.
   function automatic int outw(input int datawidth, input int columns);
      return 2 * datawidth + $clog2(columns);
   endfunction

   // Cycles from a PE sampling en to it returning to idle.
   function automatic int pe_lat(input int datawidth);
      return datawidth + 4;
   endfunction

   function automatic int sat_max(input int datawidth);
      return (1 << (datawidth - 1)) - 1;
   endfunction

   function automatic int sat_min(input int datawidth);
      return -(1 << (datawidth - 1));
   endfunction

endpackage

// File: rtl/row_drain_sequencer_if.sv
// Result stream from the row drain sequencer to its consumer.
// Handshake: a word moves on every rising clk edge where out_valid & out_ready are
// both 1; out_valid never waits on out_ready, and out_data is stable while out_valid=1.
interface row_drain_sequencer_if #(
   parameter int datawidth = 11
);
   logic signed [datawidth-1:0] out_data;
   logic                        out_valid;
   logic                        out_ready;
   logic                        fifo_full;

   modport master (output out_data, output out_valid, output fifo_full, input out_ready);
   modport slave  (input out_data, input out_valid, input fifo_full, output out_ready);
endinterface

// File: rtl/drain_fifo.sv
// Small synchronous FIFO for requantized results; the head word is registered so
// pop_data holds its last value while the FIFO is empty.
module drain_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_d;
   logic             do_push, do_pop;

   // A pop frees a slot in the same cycle, so push while full is accepted with a pop.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      head_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem[rd_ptr_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pop_data <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(do_push);
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (count_d != '0) pop_data <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/row_drain_sequencer.sv
// East-edge controller for one systolic row: fires the rst_vals/en wavefront, then
// rounds and saturates the last PE's psum into the result FIFO. Option: DRAIN_RELU_EN.
module row_drain_sequencer
   import booth_row_pkg::*;
#(
   parameter int columns    = 64,
   parameter int datawidth  = 11,
   parameter int SHIFT      = 10,
   parameter int FIFO_DEPTH = 4,
   localparam int OUTW      = outw(datawidth, columns)
) (
   input  logic                   clk,
   input  logic                   rst_overall_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   row_rst_vals,
   output logic                   row_en,
   input  logic signed [OUTW-1:0] psum_in,
   output logic                   ovf_sticky,
   output drain_state_t           state_dbg,
   row_drain_sequencer_if.master  out_if
);

   localparam int PE_LAT = pe_lat(datawidth);
   localparam int WCW    = $clog2(PE_LAT + 1);
   localparam int SCW    = $clog2(columns + 1);
   localparam int CW     = $clog2(FIFO_DEPTH) + 1;
   localparam int RSH    = (SHIFT == 0) ? 0 : SHIFT - 1;
   localparam logic signed [OUTW:0] RND    = (SHIFT == 0) ? '0 : ((OUTW + 1)'(1) << RSH);
   localparam logic signed [OUTW:0] SAT_HI = (OUTW + 1)'(sat_max(datawidth));
   localparam logic signed [OUTW:0] SAT_LO = (OUTW + 1)'(sat_min(datawidth));

   drain_state_t   state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic [SCW-1:0] stage_cnt_q, stage_cnt_d;
   logic           push, ovf_d;
   logic           fifo_full_w, fifo_empty_w;
   logic [CW-1:0]  fifo_count;

   logic signed [OUTW:0]        psum_ext, rounded;
   logic                        sat_hi, sat_lo;
   logic signed [datawidth-1:0] q_sat, q_val;

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      stage_cnt_d  = stage_cnt_q;
      row_rst_vals = 1'b0;
      row_en       = 1'b0;
      push         = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            state_d     = S_CLEAR;
            stage_cnt_d = '0;
            wait_cnt_d  = '0;
         end
         S_CLEAR: begin
            row_rst_vals = 1'b1;
            state_d      = S_FIRE;
         end
         S_FIRE: begin
            row_en     = 1'b1;
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         // FIRE plus PE_LAT-1 WAIT cycles spaces the en pulses by PE_LAT; after the
         // last pulse the same delay lands exactly on the valid outp_east.
         S_WAIT: begin
            if (wait_cnt_q == WCW'(PE_LAT - 2)) begin
               if (stage_cnt_q < SCW'(columns - 1)) begin
                  stage_cnt_d = stage_cnt_q + 1'b1;
                  state_d     = S_FIRE;
               end else begin
                  state_d = S_CAPTURE;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_CAPTURE: if (fifo_count < CW'(FIFO_DEPTH)) begin
            push    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Round half up, arithmetic shift, then clamp to the signed result range.
   always_comb begin
      psum_ext = {psum_in[OUTW-1], psum_in};
      rounded  = (psum_ext + RND) >>> SHIFT;
      sat_hi   = (rounded > SAT_HI);
      sat_lo   = (rounded < SAT_LO);
      if (sat_hi)      q_sat = SAT_HI[datawidth-1:0];
      else if (sat_lo) q_sat = SAT_LO[datawidth-1:0];
      else             q_sat = rounded[datawidth-1:0];
`ifdef DRAIN_RELU_EN
      q_val = q_sat[datawidth-1] ? '0 : q_sat;
`else
      q_val = q_sat;
`endif
      ovf_d = ovf_sticky;
      if (start && (state_q == S_IDLE)) ovf_d = 1'b0;
      if (push && (sat_hi || sat_lo))   ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_overall_n) begin
      if (!rst_overall_n) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= '0;
         stage_cnt_q <= '0;
         ovf_sticky  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stage_cnt_q <= stage_cnt_d;
         ovf_sticky  <= ovf_d;
      end
   end

   drain_fifo #(.WIDTH(datawidth), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_overall_n),
      .push      (push),
      .push_data (q_val),
      .pop       (out_if.out_ready),
      .pop_data  (out_if.out_data),
      .full      (fifo_full_w),
      .empty     (fifo_empty_w),
      .count     (fifo_count)
   );

   assign busy             = (state_q != S_IDLE);
   assign state_dbg        = state_q;
   assign out_if.out_valid = ~fifo_empty_w;
   assign out_if.fifo_full = fifo_full_w;

endmodule

// File: tb/tb_row_drain_sequencer.sv
// Bench for row_drain_sequencer (columns=4, datawidth=11, SHIFT=4, FIFO_DEPTH=4);
// expected results follow the DRAIN_RELU_EN setting of the build.
module tb_row_drain_sequencer;
  import booth_row_pkg::*;

  localparam int COLS = 4;
  localparam int DW   = 11;
  localparam int SH   = 4;
  localparam int FD   = 4;
  localparam int OW   = outw(DW, COLS);
  localparam int W    = DW;
  localparam int GAP  = DW + 4;
`ifdef DRAIN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_overall_n = 1'b0;
  logic start = 1'b0;
  logic busy, row_rst_vals, row_en, ovf_sticky;
  logic signed [OW-1:0] psum_in = '0;
  drain_state_t state_dbg;

  row_drain_sequencer_if #(.datawidth(DW)) out_if();

  row_drain_sequencer #(.columns(COLS), .datawidth(DW), .SHIFT(SH), .FIFO_DEPTH(FD)) dut (
    .clk           (clk),
    .rst_overall_n (rst_overall_n),
    .start         (start),
    .busy          (busy),
    .row_rst_vals  (row_rst_vals),
    .row_en        (row_en),
    .psum_in       (psum_in),
    .ovf_sticky    (ovf_sticky),
    .state_dbg     (state_dbg),
    .out_if        (out_if)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_total = 0;
  int rst_total = 0;
  int spacing_bad = 0;
  int last_en = 0;
  bit have_prev = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- row wavefront monitor ----------------
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_overall_n) begin
      if (row_rst_vals) begin
        rst_total++;
        have_prev = 1'b0;
      end
      if (row_en) begin
        en_total++;
        if (have_prev && (cyc - last_en != GAP)) spacing_bad++;
        last_en = cyc;
        have_prev = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rst_overall_n && out_if.out_valid && out_if.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_data: unexpected word %0d, none expected", $signed(out_if.out_data));
      end else begin
        exp_v = exp_q.pop_front();
        if (out_if.out_data !== exp_v) begin
          errors++;
          $display("FAIL out_data: got %0d, expected %0d", $signed(out_if.out_data), $signed(exp_v));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int v);
    exp_q.push_back(W'((RELU && (v < 0)) ? 0 : v));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && (n < budget)) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, int'(busy), 0);
  endtask

  task automatic wait_state(input drain_state_t st, input int budget, input string name);
    int n = 0;
    while ((state_dbg != st) && (n < budget)) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, int'(state_dbg), int'(st));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (out_if.out_valid && (n < budget)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_out_valid", int'(out_if.out_valid), 0);
  endtask

  task automatic run_pass(input int psum, input int expv, input string name);
    int en0, rst0, bad0;
    psum_in = OW'(psum);
    push_exp(expv);
    en0  = en_total;
    rst0 = rst_total;
    bad0 = spacing_bad;
    pulse_start();
    wait_idle(200, {name, "_busy"});
    chk({name, "_en_pulses"}, en_total - en0, COLS);
    chk({name, "_rst_pulses"}, rst_total - rst0, 1);
    chk({name, "_spacing_bad"}, spacing_bad - bad0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int en0, rst0;
    out_if.out_ready = 1'b1;

    // Reset state
    tick(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_row_en", int'(row_en), 0);
    chk("rst_row_rst_vals", int'(row_rst_vals), 0);
    chk("rst_out_valid", int'(out_if.out_valid), 0);
    chk("rst_fifo_full", int'(out_if.fifo_full), 0);
    chk("rst_ovf", int'(ovf_sticky), 0);
    chk("rst_out_data", int'(out_if.out_data), 0);
    chk("rst_state", int'(state_dbg), int'(S_IDLE));
    rst_overall_n = 1'b1;
    tick(2);

    // Wavefront and rounding: +40 -> 3, -40 -> -2
    run_pass(40, 3, "p40");
    chk("p40_out_valid_at_idle", int'(out_if.out_valid), 1);
    chk("p40_ovf", int'(ovf_sticky), 0);
    tick(2);
    run_pass(-40, -2, "m40");
    chk("m40_ovf", int'(ovf_sticky), 0);
    tick(2);

    // Saturation and sticky overflow
    run_pass(1 << 20, 1023, "sat_pos");
    chk("sat_pos_ovf", int'(ovf_sticky), 1);
    tick(2);
    psum_in = OW'(-(1 << 20));
    push_exp(-1024);
    pulse_start();
    wait_state(S_WAIT, 10, "sat_neg_reach_wait");
    chk("sat_neg_ovf_cleared", int'(ovf_sticky), 0);
    wait_idle(200, "sat_neg_busy");
    chk("sat_neg_ovf", int'(ovf_sticky), 1);
    tick(2);
    run_pass(100, 6, "p100");
    chk("p100_ovf", int'(ovf_sticky), 0);
    tick(2);

    // start during S_WAIT is ignored
    psum_in = OW'(200);
    push_exp(13);
    en0  = en_total;
    rst0 = rst_total;
    pulse_start();
    wait_state(S_WAIT, 10, "dup_reach_wait");
    pulse_start();
    wait_idle(200, "dup_busy");
    chk("dup_en_pulses", en_total - en0, COLS);
    chk("dup_rst_pulses", rst_total - rst0, 1);
    tick(4);
    chk("dup_no_extra_result", int'(out_if.out_valid), 0);

    // FIFO full stall and ordering
    out_if.out_ready = 1'b0;
    run_pass(17, 1, "f1");
    run_pass(24, 2, "f2");
    run_pass(-24, -1, "f3");
    run_pass(1000, 63, "f4");
    chk("full_after4", int'(out_if.fifo_full), 1);
    psum_in = OW'(-160);
    push_exp(-10);
    pulse_start();
    wait_state(S_CAPTURE, 100, "f5_reach_capture");
    tick(3);
    chk("f5_stalled_state", int'(state_dbg), int'(S_CAPTURE));
    chk("f5_stalled_busy", int'(busy), 1);
    @(posedge clk); #1 out_if.out_ready = 1'b1;
    @(posedge clk); #1 out_if.out_ready = 1'b0;
    wait_idle(10, "f5_busy");
    chk("full_after5", int'(out_if.fifo_full), 1);
    out_if.out_ready = 1'b1;
    wait_drain(20);
    chk("drained_full", int'(out_if.fifo_full), 0);

    // Reset mid-pass aborts and empties the FIFO
    out_if.out_ready = 1'b0;
    run_pass(1 << 20, 1023, "pre_rst");
    psum_in = OW'(100);
    pulse_start();
    wait_state(S_WAIT, 10, "abort_reach_wait");
    tick(5);
    #2 rst_overall_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_row_en", int'(row_en), 0);
    chk("abort_row_rst_vals", int'(row_rst_vals), 0);
    chk("abort_out_valid", int'(out_if.out_valid), 0);
    chk("abort_fifo_full", int'(out_if.fifo_full), 0);
    chk("abort_out_data", int'(out_if.out_data), 0);
    chk("abort_ovf", int'(ovf_sticky), 0);
    chk("abort_state", int'(state_dbg), int'(S_IDLE));
    exp_q.delete();
    tick(2);
    rst_overall_n = 1'b1;
    out_if.out_ready = 1'b1;
    tick(2);
    run_pass(100, 6, "post_rst");
    tick(4);
    chk("post_rst_out_valid", int'(out_if.out_valid), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
